// File: rtl/l2dr_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : l2dr_req_arb
// Description : Merges L2 and L2TLB directory requests into one outbound
//               request channel through a 2-entry FIFO. A round-robin grant
//               decides which source wins when both are valid. It also
//               splits directory snoop/ack responses back to L2 or L2TLB
//               through a 2-entry FIFO. The nodeid LSB in the response
//               payload selects the destination.
//               All channels use valid/retry handshaking. A transfer happens
//               when valid=1 and retry=0.
// Ports       : clk, reset                        - clock, sync active-high reset
//               l2_req_*  / tlb_req_*             - request sources 0 / 1
//               l2todr_req_*                      - merged request to directory
//               drtol2_snack_*                    - response from directory
//               l2_snack_* / tlb_snack_*          - responses to L2 / L2TLB
// Revision    : 1.0 - initial release
// ============================================================================
module l2dr_req_arb #(
    parameter int REQ_W   = 128,
    parameter int SNACK_W = 128,
    parameter int NID_BIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    // L2 request source (source 0)
    input  logic               l2_req_valid,
    output logic               l2_req_retry,
    input  logic [REQ_W-1:0]   l2_req,
    // L2TLB request source (source 1)
    input  logic               tlb_req_valid,
    output logic               tlb_req_retry,
    input  logic [REQ_W-1:0]   tlb_req,
    // Merged request to directory
    output logic               l2todr_req_valid,
    input  logic               l2todr_req_retry,
    output logic [REQ_W-1:0]   l2todr_req,
    // Directory response
    input  logic               drtol2_snack_valid,
    output logic               drtol2_snack_retry,
    input  logic [SNACK_W-1:0] drtol2_snack,
    // Response to L2
    output logic               l2_snack_valid,
    input  logic               l2_snack_retry,
    output logic [SNACK_W-1:0] l2_snack,
    // Response to L2TLB
    output logic               tlb_snack_valid,
    input  logic               tlb_snack_retry,
    output logic [SNACK_W-1:0] tlb_snack
);

    localparam logic [1:0] c_full = 2'd2;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic [REQ_W-1:0] r_req_mem [2];
    logic             r_req_wptr;
    logic             r_req_rptr;
    logic [1:0]       r_req_cnt;
    logic             r_last_grant;   // 0 = L2 won last, 1 = TLB won last

    logic             w_req_space;
    logic             w_req_both;
    logic             w_grant_l2;
    logic             w_grant_tlb;
    logic             w_req_enq;
    logic             w_req_deq;
    logic [REQ_W-1:0] w_req_data;

    // Space is judged on the registered count alone. A dequeue in the same
    // cycle does not open a slot. This keeps the source retries free of
    // any combinational path from l2todr_req_retry.
    assign w_req_space = !reset && (r_req_cnt != c_full);
    assign w_req_both  = l2_req_valid && tlb_req_valid;

    // On a tie, the source that did not win last time gets the grant.
    assign l2_req_retry  = !w_req_space || (w_req_both && !r_last_grant);
    assign tlb_req_retry = !w_req_space || (w_req_both &&  r_last_grant);

    assign w_grant_l2  = l2_req_valid  && !l2_req_retry;
    assign w_grant_tlb = tlb_req_valid && !tlb_req_retry;
    assign w_req_enq   = w_grant_l2 || w_grant_tlb;
    assign w_req_data  = w_grant_tlb ? tlb_req : l2_req;
    assign w_req_deq   = (r_req_cnt != 2'd0) && !l2todr_req_retry;

    assign l2todr_req_valid = (r_req_cnt != 2'd0);
    assign l2todr_req       = r_req_mem[r_req_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_wptr   <= 1'b0;
            r_req_rptr   <= 1'b0;
            r_req_cnt    <= 2'd0;
            r_last_grant <= 1'b1;   // makes L2 win the first tie
        end else begin
            if (w_req_enq) begin
                r_req_wptr   <= ~r_req_wptr;
                r_last_grant <= w_grant_tlb;
            end
            if (w_req_deq) begin
                r_req_rptr <= ~r_req_rptr;
            end
            case ({w_req_enq, w_req_deq})
                2'b10:   r_req_cnt <= r_req_cnt + 2'd1;
                2'b01:   r_req_cnt <= r_req_cnt - 2'd1;
                default: r_req_cnt <= r_req_cnt;
            endcase
        end
    end

    // Payload storage is never cleared. The count alone marks entries valid.
    always_ff @(posedge clk) begin
        if (w_req_enq) begin
            r_req_mem[r_req_wptr] <= w_req_data;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic [SNACK_W-1:0] r_rsp_mem [2];
    logic               r_rsp_wptr;
    logic               r_rsp_rptr;
    logic [1:0]         r_rsp_cnt;

    logic               w_rsp_enq;
    logic               w_rsp_deq;
    logic               w_rsp_nonempty;
    logic               w_rsp_to_tlb;
    logic [SNACK_W-1:0] w_rsp_head;

    assign drtol2_snack_retry = reset || (r_rsp_cnt == c_full);
    assign w_rsp_enq          = drtol2_snack_valid && !drtol2_snack_retry;

    assign w_rsp_nonempty = (r_rsp_cnt != 2'd0);
    assign w_rsp_head     = r_rsp_mem[r_rsp_rptr];
    assign w_rsp_to_tlb   = w_rsp_head[NID_BIT];

    assign l2_snack_valid  = w_rsp_nonempty && !w_rsp_to_tlb;
    assign tlb_snack_valid = w_rsp_nonempty &&  w_rsp_to_tlb;
    assign l2_snack        = w_rsp_head;
    assign tlb_snack       = w_rsp_head;

    // Delivery is strictly in order. Only the selected destination's retry
    // can stall the head.
    assign w_rsp_deq = w_rsp_nonempty &&
                       (w_rsp_to_tlb ? !tlb_snack_retry : !l2_snack_retry);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_wptr <= 1'b0;
            r_rsp_rptr <= 1'b0;
            r_rsp_cnt  <= 2'd0;
        end else begin
            if (w_rsp_enq) begin
                r_rsp_wptr <= ~r_rsp_wptr;
            end
            if (w_rsp_deq) begin
                r_rsp_rptr <= ~r_rsp_rptr;
            end
            case ({w_rsp_enq, w_rsp_deq})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + 2'd1;
                2'b01:   r_rsp_cnt <= r_rsp_cnt - 2'd1;
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_enq) begin
            r_rsp_mem[r_rsp_wptr] <= drtol2_snack;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2dr_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2dr_req_arb
// Description : Self-checking bench for l2dr_req_arb. A queue-based
//               reference model predicts every output each cycle. Directed
//               scenarios run first, followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2dr_req_arb;

    localparam int REQ_W   = 128;
    localparam int SNACK_W = 128;
    localparam int NID_BIT = 0;

    logic               clk = 1'b0;
    logic               reset;
    logic               l2_req_valid, l2_req_retry;
    logic [REQ_W-1:0]   l2_req;
    logic               tlb_req_valid, tlb_req_retry;
    logic [REQ_W-1:0]   tlb_req;
    logic               l2todr_req_valid, l2todr_req_retry;
    logic [REQ_W-1:0]   l2todr_req;
    logic               drtol2_snack_valid, drtol2_snack_retry;
    logic [SNACK_W-1:0] drtol2_snack;
    logic               l2_snack_valid, l2_snack_retry;
    logic [SNACK_W-1:0] l2_snack;
    logic               tlb_snack_valid, tlb_snack_retry;
    logic [SNACK_W-1:0] tlb_snack;

    l2dr_req_arb #(.REQ_W(REQ_W), .SNACK_W(SNACK_W), .NID_BIT(NID_BIT)) dut (
        .clk                (clk),
        .reset              (reset),
        .l2_req_valid       (l2_req_valid),
        .l2_req_retry       (l2_req_retry),
        .l2_req             (l2_req),
        .tlb_req_valid      (tlb_req_valid),
        .tlb_req_retry      (tlb_req_retry),
        .tlb_req            (tlb_req),
        .l2todr_req_valid   (l2todr_req_valid),
        .l2todr_req_retry   (l2todr_req_retry),
        .l2todr_req         (l2todr_req),
        .drtol2_snack_valid (drtol2_snack_valid),
        .drtol2_snack_retry (drtol2_snack_retry),
        .drtol2_snack       (drtol2_snack),
        .l2_snack_valid     (l2_snack_valid),
        .l2_snack_retry     (l2_snack_retry),
        .l2_snack           (l2_snack),
        .tlb_snack_valid    (tlb_snack_valid),
        .tlb_snack_retry    (tlb_snack_retry),
        .tlb_snack          (tlb_snack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: buffered items in arrival order, plus the
    // source that won the most recent grant (0 = L2, 1 = TLB).
    logic [REQ_W-1:0]   mq_req [$];
    logic [SNACK_W-1:0] mq_rsp [$];
    bit                 m_last = 1'b1;

    // Results of the most recent step, used to sequence stimulus.
    bit acc_l2, acc_tlb, acc_rsp;

    // What the DUT actually delivered downstream.
    logic [REQ_W-1:0]   out_log [$];
    logic [SNACK_W-1:0] rsp_log [$];
    bit                 dst_log [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle. It is entered at a falling edge with inputs already
    // driven. It checks outputs against the model, crosses the rising edge,
    // updates the model and returns at the next falling edge.
    task automatic step();
        bit space, g_l2, g_tlb, rdeq, senq, sdeq, sel;
        #1;
        chk("l2todr_req_valid", l2todr_req_valid, mq_req.size() != 0);
        if (mq_req.size() != 0) chk("l2todr_req", l2todr_req, mq_req[0]);
        space = !reset && mq_req.size() < 2;
        g_l2  = space && l2_req_valid  && (!tlb_req_valid || m_last);
        g_tlb = space && tlb_req_valid && (!l2_req_valid  || !m_last);
        if (l2_req_valid  || !space) chk("l2_req_retry",  l2_req_retry,  !g_l2);
        if (tlb_req_valid || !space) chk("tlb_req_retry", tlb_req_retry, !g_tlb);
        rdeq = mq_req.size() != 0 && !l2todr_req_retry;

        chk("drtol2_snack_retry", drtol2_snack_retry, reset || mq_rsp.size() == 2);
        senq = drtol2_snack_valid && !reset && mq_rsp.size() < 2;
        sdeq = 1'b0;
        if (mq_rsp.size() != 0) begin
            sel = mq_rsp[0][NID_BIT];
            chk("l2_snack_valid",  l2_snack_valid,  !sel);
            chk("tlb_snack_valid", tlb_snack_valid, sel);
            chk("l2_snack",  l2_snack,  mq_rsp[0]);
            chk("tlb_snack", tlb_snack, mq_rsp[0]);
            sdeq = sel ? !tlb_snack_retry : !l2_snack_retry;
        end else begin
            chk("l2_snack_valid_idle",  l2_snack_valid,  1'b0);
            chk("tlb_snack_valid_idle", tlb_snack_valid, 1'b0);
        end

        if (!reset) begin
            if (l2todr_req_valid && !l2todr_req_retry) out_log.push_back(l2todr_req);
            if (l2_snack_valid && !l2_snack_retry) begin
                rsp_log.push_back(l2_snack); dst_log.push_back(1'b0);
            end
            if (tlb_snack_valid && !tlb_snack_retry) begin
                rsp_log.push_back(tlb_snack); dst_log.push_back(1'b1);
            end
        end
        acc_l2 = g_l2; acc_tlb = g_tlb; acc_rsp = senq;

        @(posedge clk);
        if (reset) begin
            mq_req.delete(); mq_rsp.delete(); m_last = 1'b1;
        end else begin
            if (rdeq) void'(mq_req.pop_front());
            if (g_l2)  begin mq_req.push_back(l2_req);  m_last = 1'b0; end
            if (g_tlb) begin mq_req.push_back(tlb_req); m_last = 1'b1; end
            if (sdeq) void'(mq_rsp.pop_front());
            if (senq) mq_rsp.push_back(drtol2_snack);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [REQ_W-1:0] exp_req [$];
        logic [REQ_W-1:0] pay [3];
        int idx;
        reset = 1'b1;
        l2_req_valid = 1'b0; l2_req = '0; tlb_req_valid = 1'b0; tlb_req = '0;
        l2todr_req_retry = 1'b0;
        drtol2_snack_valid = 1'b0; drtol2_snack = '0;
        l2_snack_retry = 1'b0; tlb_snack_retry = 1'b0;
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        step();

        // Tie after reset goes to L2: 0xA then 0xB.
        out_log.delete();
        l2_req_valid = 1'b1; l2_req = 128'hA; tlb_req_valid = 1'b1; tlb_req = 128'hB;
        step();
        chk("first_tie_l2", acc_l2, 1'b1);
        l2_req_valid = 1'b0;
        step();
        tlb_req_valid = 1'b0;
        step(); step();
        chk("seq_ab_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("seq_ab_0", out_log[0], 128'hA);
            chk("seq_ab_1", out_log[1], 128'hB);
        end

        // Continuous tie for 8 cycles: strict alternation, 4 of each.
        out_log.delete();
        for (int i = 0; i < 8; i++)
            exp_req.push_back((i % 2 == 0) ? 128'h100 + i / 2 : 128'h200 + i / 2);
        l2_req_valid = 1'b1; l2_req = 128'h100; tlb_req_valid = 1'b1; tlb_req = 128'h200;
        for (int i = 0; i < 8; i++) begin
            step();
            if (acc_l2)  l2_req  = l2_req + 1;
            if (acc_tlb) tlb_req = tlb_req + 1;
        end
        l2_req_valid = 1'b0; tlb_req_valid = 1'b0;
        step(); step(); step();
        chk("alt_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("alt_order", out_log[i], exp_req[i]);

        // Downstream stalled: third L2 request waits until a dequeue.
        out_log.delete();
        pay[0] = 128'hC0; pay[1] = 128'hC1; pay[2] = 128'hC2;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            l2_req_valid = (idx < 3);
            l2_req = pay[idx < 3 ? idx : 2];
            l2todr_req_retry = (c < 5);
            step();
            if (c == 4) chk("stall_accepted", idx, 2);
            if (acc_l2) idx++;
        end
        l2_req_valid = 1'b0; l2todr_req_retry = 1'b0;
        step();
        chk("stall_count", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            chk("stall_order", out_log[i], pay[i]);

        // Responses nodeid 4, 7, 2 route L2, TLB, L2.
        rsp_log.delete(); dst_log.delete();
        pay[0] = 128'h4; pay[1] = 128'h7; pay[2] = 128'h2;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            drtol2_snack_valid = (idx < 3);
            drtol2_snack = pay[idx < 3 ? idx : 2];
            step();
            if (acc_rsp) idx++;
        end
        drtol2_snack_valid = 1'b0;
        chk("rsp_count", rsp_log.size(), 3);
        if (dst_log.size() == 3) begin
            chk("rsp_dst0", dst_log[0], 1'b0);
            chk("rsp_dst1", dst_log[1], 1'b1);
            chk("rsp_dst2", dst_log[2], 1'b0);
        end

        // Head nodeid 3 blocked by TLB retry; nodeid 2 waits behind it.
        rsp_log.delete(); dst_log.delete();
        pay[0] = 128'h3; pay[1] = 128'h2; pay[2] = 128'h6;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            drtol2_snack_valid = (idx < 3);
            drtol2_snack = pay[idx < 3 ? idx : 2];
            tlb_snack_retry = (c < 5);
            step();
            if (c == 3) chk("hol_blocked", rsp_log.size(), 0);
            if (acc_rsp) idx++;
        end
        drtol2_snack_valid = 1'b0; tlb_snack_retry = 1'b0;
        step();
        chk("hol_count", rsp_log.size(), 3);
        for (int i = 0; i < 3 && i < rsp_log.size(); i++)
            chk("hol_order", rsp_log[i], pay[i]);

        // Reset with 2 requests and 1 response buffered, then a tie.
        l2todr_req_retry = 1'b1; l2_snack_retry = 1'b1; tlb_snack_retry = 1'b1;
        l2_req_valid = 1'b1; l2_req = 128'hD0; tlb_req_valid = 1'b0;
        step();
        l2_req_valid = 1'b0; tlb_req_valid = 1'b1; tlb_req = 128'hD1;
        drtol2_snack_valid = 1'b1; drtol2_snack = 128'hE4;
        step();
        tlb_req_valid = 1'b0; drtol2_snack_valid = 1'b0;
        chk("pre_reset_held", l2todr_req_valid && l2_snack_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0; l2todr_req_retry = 1'b0; l2_snack_retry = 1'b0; tlb_snack_retry = 1'b0;
        l2_req_valid = 1'b1; l2_req = 128'hF0; tlb_req_valid = 1'b1; tlb_req = 128'hF1;
        step();
        chk("post_reset_tie_l2", acc_l2, 1'b1);
        l2_req_valid = 1'b0; tlb_req_valid = 1'b0;
        step(); step();

        // Randomized traffic; sources hold valid/payload while retried.
        for (int c = 0; c < 600; c++) begin
            if (!l2_req_valid || acc_l2) begin
                l2_req_valid = $urandom_range(0, 1) == 1; l2_req = rnd128();
            end
            if (!tlb_req_valid || acc_tlb) begin
                tlb_req_valid = $urandom_range(0, 1) == 1; tlb_req = rnd128();
            end
            if (!drtol2_snack_valid || acc_rsp) begin
                drtol2_snack_valid = $urandom_range(0, 1) == 1; drtol2_snack = rnd128();
            end
            l2todr_req_retry = $urandom_range(0, 3) == 0;
            l2_snack_retry   = $urandom_range(0, 3) == 0;
            tlb_snack_retry  = $urandom_range(0, 3) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
